mpu_sample_sequencer: RTL and testbench
=======================================

Name: mpu_sample_sequencer

Overview:
Transaction-level controller that sequences the byte-level I2C master for the MPU6050 IMU. After `start` it runs a fixed register-init script, then issues a 14-byte burst read from ACCEL_XOUT_H (0x3B) at a fixed sample rate. It packs the burst into seven signed 16-bit words and retries NACKed transactions with backoff. It sits between the I2C master and the attitude/filter datapath.

Parameters:
- CLK_MAIN, 50000000: main clock frequency in Hz.
- SAMPLE_HZ, 1000: burst-read rate; tick period TICK_CYC = CLK_MAIN/SAMPLE_HZ cycles (integer divide).
- DEV_ADDR, 7'h68: MPU6050 7-bit address.
- MAX_RETRY, 3: consecutive NACKed attempts allowed per transaction before fault.
- BACKOFF_CYC, 1000: idle cycles between a NACK and the reissue.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; leaves IDLE or FAULT and begins the init script
- busy  out  1  high whenever state is not IDLE or FAULT
- init_done  out  1  set after the last init write is ACKed; cleared by rst or start
- fault  out  1  retry budget exhausted; held until rst or start
- sample_valid  out  1  one-cycle pulse; all sample words are updated in the same cycle
- accel_x/accel_y/accel_z/temp/gyro_x/gyro_y/gyro_z  out  16 each  signed sample words
- overrun_cnt  out  8  saturating count of ticks dropped
- m_req  out  1  transaction request to the I2C master
- m_ack  in  1  master accepted the request (one-cycle pulse)
- m_rw  out  1  0 = write, 1 = read
- m_addr  out  7  device address (always DEV_ADDR)
- m_reg  out  8  register pointer
- m_len  out  4  byte count (1 for writes, 14 for reads)
- m_wdata  out  8  write data byte
- m_rd_valid  in  1  one read byte is valid this cycle
- m_rd_data  in  8  read byte
- m_done  in  1  end-of-transaction pulse (after STOP)
- m_nack  in  1  qualifies m_done: the transaction failed

Behaviour:
Reset values:
- All outputs are 0, including all sample words and overrun_cnt.
- State is IDLE.
- Internal counters are 0.
- rst mid-transaction drops m_req the same cycle; the I2C master shares rst.

Request handshake:
- m_req rises with m_rw/m_reg/m_len/m_wdata valid.
- Those fields stay stable until the cycle m_ack=1; m_req drops the following cycle.
- Only one transaction is outstanding at a time.

State machine:
- IDLE: on start, clear fault/init_done/retry/rom index and go to INIT_ISSUE.
- INIT_ISSUE: issue a write of ROM[idx] (reg, data). On m_ack go to INIT_WAIT.
- INIT_WAIT, on m_done with m_nack=0:
  - If idx==4: set init_done and go to WAIT_TICK.
  - Otherwise: idx++ and go to INIT_ISSUE.
- INIT_WAIT, on m_done with m_nack=1: go to the retry path.
- Init ROM, in order: (0x6B,0x00), (0x19,0x07), (0x1A,0x03), (0x1B,0x08), (0x1C,0x08).
- WAIT_TICK: on a tick or a pending tick, clear pending, set byte_cnt=0 and go to READ_ISSUE.
- READ_ISSUE: issue read reg 0x3B, len 14. On m_ack go to READ_COLLECT.
- READ_COLLECT, each m_rd_valid:
  - If byte_cnt<14, store the byte into shadow[byte_cnt] and byte_cnt++.
  - Bytes beyond the 14th are ignored.
- READ_COLLECT, on m_done:
  - If m_nack=0 and byte_cnt==14: go to PUBLISH.
  - If m_nack=1 or byte_cnt<14: go to the retry path.
- PUBLISH (1 cycle):
  - Load the outputs from shadow, big-endian: word k = {shadow[2k], shadow[2k+1]}.
  - Word order is accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z.
  - Pulse sample_valid, clear the retry counter, go to WAIT_TICK.
  - Latency: sample_valid is asserted exactly 1 cycle after the accepting m_done.
- Retry path:
  - retry++. If retry==MAX_RETRY: set fault and go to FAULT.
  - Otherwise go to BACKOFF, count BACKOFF_CYC cycles, then reissue the same transaction (same ROM idx, or the same burst).
- A successful transaction clears retry.
- FAULT: outputs hold their last samples; start restarts from IDLE behaviour.

Tick generation:
- Free-running counter, enabled only while init_done=1.
- Wraps at TICK_CYC-1 and emits a one-cycle tick on the wrap.
- A tick outside WAIT_TICK sets pending.
- A tick while pending is already set increments overrun_cnt, saturating at 255.
- Tick and WAIT_TICK exit in the same cycle: the tick is consumed; no pending or overrun.

Other boundary rules:
- start while busy is ignored.
- m_done without an outstanding transaction is ignored.

Decomposition:
- Shared package mpu_pkg holds:
  - the state enum;
  - register constants (PWR_MGMT_1=0x6B, SMPLRT_DIV=0x19, CONFIG=0x1A, GYRO_CONFIG=0x1B, ACCEL_CONFIG=0x1C, ACCEL_XOUT_H=0x3B);
  - the init-ROM table;
  - BURST_LEN=14.
- One sub-module, sample_tick_gen (counter plus enable, tick output), instanced once.

Test Plan:
- Init: start, master model ACKs everything -> five writes in ROM order, each m_len=1, m_addr=0x68; init_done=1 after the 5th m_done.
- Sample: burst bytes 0x01..0x0E -> sample_valid 1 cycle after m_done; accel_x=0x0102, temp=0x0708, gyro_z=0x0D0E; next m_req follows after TICK_CYC.
- NACK recovery: NACK the first attempt of ROM write 2 -> reissue of (0x19,0x07) exactly BACKOFF_CYC cycles later; the ACK proceeds to write 3; fault=0.
- Fault: NACK every attempt with MAX_RETRY=3 -> three attempts, then fault=1, busy=0; a later start clears fault and reissues (0x6B,0x00).
- Overrun/short burst:
  - Stall the master's m_ack for 3×TICK_CYC -> overrun_cnt=2.
  - Deliver only 12 bytes then m_done -> retry; sample words unchanged until a full burst.
- Reset mid-burst: assert rst after 6 bytes -> next cycle m_req=0, all outputs 0, state IDLE; no sample_valid.

Source files
------------

// File: rtl/mpu_sample_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mpu_pkg: shared definitions for the MPU6050 sample sequencer.
//   - state_t     : sequencer state encoding
//   - register map: MPU6050 register pointers used by the sequencer
//   - init_rom()  : (register, data) pairs written once after start
//   - BURST_LEN   : bytes per ACCEL_XOUT_H burst read
// ---------------------------------------------------------------------------
package mpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_WAIT_TICK,
        S_READ_ISSUE,
        S_READ_COLLECT,
        S_PUBLISH,
        S_BACKOFF,
        S_FAULT
    } state_t;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] SMPLRT_DIV   = 8'h19;
    localparam logic [7:0] CONFIG       = 8'h1A;
    localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
    localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;

    localparam int unsigned BURST_LEN = 14;
    localparam int unsigned INIT_LEN  = 5;

    // Returns {register, data} for init step idx.
    function automatic logic [15:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return {PWR_MGMT_1,   8'h00};
            3'd1:    return {SMPLRT_DIV,   8'h07};
            3'd2:    return {CONFIG,       8'h03};
            3'd3:    return {GYRO_CONFIG,  8'h08};
            3'd4:    return {ACCEL_CONFIG, 8'h08};
            default: return {PWR_MGMT_1,   8'h00};
        endcase
    endfunction

endpackage

// File: rtl/mpu_sample_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen: free-running sample-rate tick.
//   clk    in  main clock
//   rst    in  synchronous active-high reset
//   i_en   in  counter runs only while high; held at 0 otherwise
//   o_tick out one-cycle pulse on the TICK_CYC-1 -> 0 wrap
// ---------------------------------------------------------------------------
module sample_tick_gen #(
    parameter int unsigned TICK_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned LP_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [LP_W-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == LP_W'(TICK_CYC - 1));
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mpu_sample_sequencer.sv
// ---------------------------------------------------------------------------
// mpu_sample_sequencer: drives a byte-level I2C master to initialise an
// MPU6050, then burst-reads the 14 sample bytes at a fixed rate and publishes
// them as seven signed 16-bit words. NACKed or short transactions are retried
// after a backoff; exhausting the retry budget parks the block in FAULT.
//   clk, rst            main clock, synchronous active-high reset
//   start               begin init script (honoured only in IDLE/FAULT)
//   busy/init_done/fault status
//   sample_valid        one-cycle pulse, sample words updated together
//   accel_*/temp/gyro_* signed sample words
//   overrun_cnt         saturating count of dropped ticks
//   m_*                 request/response interface to the I2C master
// ---------------------------------------------------------------------------
module mpu_sample_sequencer
    import mpu_pkg::*;
#(
    parameter int unsigned CLK_MAIN    = 50000000,
    parameter int unsigned SAMPLE_HZ   = 1000,
    parameter logic [6:0]  DEV_ADDR    = 7'h68,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               init_done,
    output logic               fault,
    output logic               sample_valid,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic [7:0]         overrun_cnt,
    output logic               m_req,
    input  logic               m_ack,
    output logic               m_rw,
    output logic [6:0]         m_addr,
    output logic [7:0]         m_reg,
    output logic [3:0]         m_len,
    output logic [7:0]         m_wdata,
    input  logic               m_rd_valid,
    input  logic [7:0]         m_rd_data,
    input  logic               m_done,
    input  logic               m_nack
);

    localparam int unsigned TICK_CYC     = CLK_MAIN / SAMPLE_HZ;
    localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);

    state_t      r_state;
    state_t      r_resume;
    logic        r_busy, r_init_done, r_fault, r_sample_valid, r_pending;
    logic [7:0]  r_overrun;
    logic [7:0]  r_retry;
    logic [2:0]  r_idx;
    logic [3:0]  r_byte_cnt;
    logic [31:0] r_bo_cnt;
    logic [7:0]  r_shadow [BURST_LEN];
    logic [15:0] r_words  [7];
    logic        r_m_req, r_m_rw;
    logic [6:0]  r_m_addr;
    logic [7:0]  r_m_reg, r_m_wdata;
    logic [3:0]  r_m_len;
    logic [15:0] w_rom;
    logic        w_tick;
    logic        w_fail;

    sample_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_init_done),
        .o_tick (w_tick)
    );

    assign w_rom  = init_rom(r_idx);
    // A short burst counts as a failed transaction just like a NACK.
    assign w_fail = m_done && (((r_state == S_INIT_WAIT) && m_nack) ||
                               ((r_state == S_READ_COLLECT) &&
                                (m_nack || (r_byte_cnt != 4'(BURST_LEN)))));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_resume       <= S_IDLE;
            r_busy         <= 1'b0;
            r_init_done    <= 1'b0;
            r_fault        <= 1'b0;
            r_sample_valid <= 1'b0;
            r_pending      <= 1'b0;
            r_overrun      <= '0;
            r_retry        <= '0;
            r_idx          <= '0;
            r_byte_cnt     <= '0;
            r_bo_cnt       <= '0;
            r_shadow       <= '{default: '0};
            r_words        <= '{default: '0};
            r_m_req        <= 1'b0;
            r_m_rw         <= 1'b0;
            r_m_addr       <= '0;
            r_m_reg        <= '0;
            r_m_len        <= '0;
            r_m_wdata      <= '0;
        end else begin
            r_sample_valid <= 1'b0;

            // A tick that WAIT_TICK cannot consume is remembered once; further
            // ticks while one is already pending are counted as dropped.
            if (w_tick && (r_state != S_WAIT_TICK)) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end

            case (r_state)
                S_IDLE, S_FAULT: begin
                    if (start) begin
                        r_fault     <= 1'b0;
                        r_init_done <= 1'b0;
                        r_retry     <= '0;
                        r_idx       <= '0;
                        r_pending   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_INIT_ISSUE;
                    end
                end
                S_INIT_ISSUE: begin
                    if (!r_m_req) begin
                        r_m_req   <= 1'b1;
                        r_m_rw    <= 1'b0;
                        r_m_addr  <= DEV_ADDR;
                        r_m_reg   <= w_rom[15:8];
                        r_m_len   <= 4'd1;
                        r_m_wdata <= w_rom[7:0];
                    end else if (m_ack) begin
                        r_m_req <= 1'b0;
                        r_state <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT: begin
                    if (m_done && !m_nack) begin
                        r_retry <= '0;
                        if (r_idx == 3'(INIT_LEN - 1)) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_WAIT_TICK;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_INIT_ISSUE;
                        end
                    end
                end
                S_WAIT_TICK: begin
                    if (w_tick || r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= S_READ_ISSUE;
                    end
                end
                S_READ_ISSUE: begin
                    if (!r_m_req) begin
                        r_m_req    <= 1'b1;
                        r_m_rw     <= 1'b1;
                        r_m_addr   <= DEV_ADDR;
                        r_m_reg    <= ACCEL_XOUT_H;
                        r_m_len    <= 4'(BURST_LEN);
                        r_m_wdata  <= '0;
                        r_byte_cnt <= '0;
                    end else if (m_ack) begin
                        r_m_req <= 1'b0;
                        r_state <= S_READ_COLLECT;
                    end
                end
                S_READ_COLLECT: begin
                    if (m_rd_valid && (r_byte_cnt < 4'(BURST_LEN))) begin
                        r_shadow[r_byte_cnt] <= m_rd_data;
                        r_byte_cnt           <= r_byte_cnt + 4'd1;
                    end
                    // Words and sample_valid are loaded on the accepting edge so
                    // they appear together during the PUBLISH cycle.
                    if (m_done && !w_fail) begin
                        r_words[0]     <= {r_shadow[0],  r_shadow[1]};
                        r_words[1]     <= {r_shadow[2],  r_shadow[3]};
                        r_words[2]     <= {r_shadow[4],  r_shadow[5]};
                        r_words[3]     <= {r_shadow[6],  r_shadow[7]};
                        r_words[4]     <= {r_shadow[8],  r_shadow[9]};
                        r_words[5]     <= {r_shadow[10], r_shadow[11]};
                        r_words[6]     <= {r_shadow[12], r_shadow[13]};
                        r_sample_valid <= 1'b1;
                        r_state        <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    r_retry <= '0;
                    r_state <= S_WAIT_TICK;
                end
                S_BACKOFF: begin
                    // r_bo_cnt starts at 1, so the reissued m_req rises exactly
                    // BACKOFF_CYC edges after the failing m_done.
                    if ((r_bo_cnt + 32'd1) >= BACKOFF_CYC) begin
                        r_state <= r_resume;
                    end else begin
                        r_bo_cnt <= r_bo_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_fail) begin
                r_retry  <= r_retry + 8'd1;
                r_resume <= (r_state == S_INIT_WAIT) ? S_INIT_ISSUE : S_READ_ISSUE;
                if ((r_retry + 8'd1) == LP_MAX_RETRY) begin
                    r_fault <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_FAULT;
                end else begin
                    r_bo_cnt <= 32'd1;
                    r_state  <= S_BACKOFF;
                end
            end
        end
    end

    assign busy         = r_busy;
    assign init_done    = r_init_done;
    assign fault        = r_fault;
    assign sample_valid = r_sample_valid;
    assign overrun_cnt  = r_overrun;
    assign accel_x      = r_words[0];
    assign accel_y      = r_words[1];
    assign accel_z      = r_words[2];
    assign temp         = r_words[3];
    assign gyro_x       = r_words[4];
    assign gyro_y       = r_words[5];
    assign gyro_z       = r_words[6];
    assign m_req        = r_m_req;
    assign m_rw         = r_m_rw;
    assign m_addr       = r_m_addr;
    assign m_reg        = r_m_reg;
    assign m_len        = r_m_len;
    assign m_wdata      = r_m_wdata;

endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpu_sample_sequencer: directed bench acting as the I2C master.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mpu_sample_sequencer;

    localparam int unsigned TB_CLK     = 100000;
    localparam int unsigned TB_HZ      = 1000;
    localparam int unsigned TB_TICK    = TB_CLK / TB_HZ;   // 100 cycles
    localparam int unsigned TB_BACKOFF = 20;
    localparam int unsigned TB_RETRY   = 3;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, init_done, fault, sample_valid;
    logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic [7:0]  overrun_cnt;
    logic        m_req, m_ack, m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_reg, m_wdata, m_rd_data;
    logic [3:0]  m_len;
    logic        m_rd_valid, m_done, m_nack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rom_reg  [5] = '{8'h6B, 8'h19, 8'h1A, 8'h1B, 8'h1C};
    logic [7:0] rom_data [5] = '{8'h00, 8'h07, 8'h03, 8'h08, 8'h08};

    mpu_sample_sequencer #(
        .CLK_MAIN    (TB_CLK),
        .SAMPLE_HZ   (TB_HZ),
        .DEV_ADDR    (7'h68),
        .MAX_RETRY   (TB_RETRY),
        .BACKOFF_CYC (TB_BACKOFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .init_done    (init_done),
        .fault        (fault),
        .sample_valid (sample_valid),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .temp         (temp),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .overrun_cnt  (overrun_cnt),
        .m_req        (m_req),
        .m_ack        (m_ack),
        .m_rw         (m_rw),
        .m_addr       (m_addr),
        .m_reg        (m_reg),
        .m_len        (m_len),
        .m_wdata      (m_wdata),
        .m_rd_valid   (m_rd_valid),
        .m_rd_data    (m_rd_data),
        .m_done       (m_done),
        .m_nack       (m_nack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for m_req; returns the cycle count at the first
    // falling edge where it is seen high.
    task automatic wait_req(input string tag, output int t);
        int n;
        n = 0;
        while (m_req !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, 32'(n < 2000), 32'd1);
        t = cyc;
    endtask

    task automatic handshake(input string tag);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(m_req), 32'd0);
    endtask

    task automatic deliver(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            m_rd_valid = 1'b1;
            m_rd_data  = base + 8'(i);
            @(negedge clk);
        end
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
    endtask

    // Returns at the falling edge right after the edge that sampled m_done.
    task automatic done_pulse(input logic nack);
        @(negedge clk);
        m_done = 1'b1;
        m_nack = nack;
        @(negedge clk);
        m_done = 1'b0;
        m_nack = 1'b0;
    endtask

    task automatic chk_write(input string tag, input int i);
        chk({tag, "_rw"},    32'(m_rw),    32'd0);
        chk({tag, "_addr"},  32'(m_addr),  32'h68);
        chk({tag, "_reg"},   32'(m_reg),   32'(rom_reg[i]));
        chk({tag, "_len"},   32'(m_len),   32'd1);
        chk({tag, "_wdata"}, 32'(m_wdata), 32'(rom_data[i]));
    endtask

    task automatic chk_read(input string tag);
        chk({tag, "_rw"},   32'(m_rw),   32'd1);
        chk({tag, "_addr"}, 32'(m_addr), 32'h68);
        chk({tag, "_reg"},  32'(m_reg),  32'h3B);
        chk({tag, "_len"},  32'(m_len),  32'd14);
    endtask

    initial begin
        int t0, t1, t_done, seen;

        rst = 1'b1; start = 1'b0; m_ack = 1'b0; m_rd_valid = 1'b0;
        m_rd_data = '0; m_done = 1'b0; m_nack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_init_done", 32'(init_done),    32'd0);
        chk("rst_fault",     32'(fault),        32'd0);
        chk("rst_valid",     32'(sample_valid), 32'd0);
        chk("rst_m_req",     32'(m_req),        32'd0);
        chk("rst_accel_x",   32'(accel_x),      32'd0);
        chk("rst_overrun",   32'(overrun_cnt),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Init script; write index 1 is NACKed once
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_req("init", t0);
            chk_write("init", i);
            handshake("init");
            if (i == 1) begin
                done_pulse(1'b1);
                t_done = cyc;
                chk("nack_fault", 32'(fault), 32'd0);
                wait_req("reissue", t1);
                chk("backoff_delay", 32'(t1 - t_done), 32'(TB_BACKOFF));
                chk_write("reissue", 1);
                handshake("reissue");
            end
            if (i == 4) chk("init_done_early", 32'(init_done), 32'd0);
            done_pulse(1'b0);
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_fault", 32'(fault), 32'd0);

        // First burst: bytes 0x01..0x0E
        wait_req("rd1", t0);
        chk_read("rd1");
        handshake("rd1");
        deliver(14, 8'h01);
        chk("rd1_valid_before", 32'(sample_valid), 32'd0);
        done_pulse(1'b0);
        chk("rd1_valid",   32'(sample_valid), 32'd1);
        chk("rd1_accel_x", 32'(accel_x), 32'h0102);
        chk("rd1_accel_y", 32'(accel_y), 32'h0304);
        chk("rd1_temp",    32'(temp),    32'h0708);
        chk("rd1_gyro_z",  32'(gyro_z),  32'h0D0E);
        @(negedge clk);
        chk("rd1_valid_pulse", 32'(sample_valid), 32'd0);

        // Next burst follows one tick period later; deliver only 12 bytes
        wait_req("rd2", t1);
        chk("tick_period", 32'(t1 - t0), 32'(TB_TICK));
        chk_read("rd2");
        handshake("rd2");
        deliver(12, 8'h41);
        done_pulse(1'b0);
        t_done = cyc;
        chk("short_valid",   32'(sample_valid), 32'd0);
        chk("short_accel_x", 32'(accel_x), 32'h0102);
        wait_req("rd2_retry", t1);
        chk("short_backoff", 32'(t1 - t_done), 32'(TB_BACKOFF));
        chk_read("rd2_retry");
        chk("short_hold_gyro_z", 32'(gyro_z), 32'h0D0E);
        handshake("rd2_retry");
        deliver(14, 8'h11);
        done_pulse(1'b0);
        chk("rd2_valid",   32'(sample_valid), 32'd1);
        chk("rd2_accel_x", 32'(accel_x), 32'h1112);
        chk("rd2_gyro_x",  32'(gyro_x),  32'h191A);
        chk("rd2_gyro_z",  32'(gyro_z),  32'h1D1E);
        chk("rd2_overrun", 32'(overrun_cnt), 32'd0);

        // Stall m_ack past three tick periods: one pending + two overruns
        wait_req("rd3", t0);
        repeat (3 * TB_TICK + 5) @(negedge clk);
        chk("stall_req_held", 32'(m_req), 32'd1);
        chk("stall_reg_held", 32'(m_reg), 32'h3B);
        handshake("rd3");
        deliver(14, 8'h21);
        done_pulse(1'b0);
        chk("rd3_valid",   32'(sample_valid), 32'd1);
        chk("rd3_accel_x", 32'(accel_x), 32'h2122);
        chk("overrun",     32'(overrun_cnt), 32'd2);

        // Pending tick launches a burst immediately; reset it after 6 bytes
        wait_req("rd4", t0);
        handshake("rd4");
        deliver(6, 8'h31);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_req",     32'(m_req),        32'd0);
        chk("mid_rst_busy",      32'(busy),         32'd0);
        chk("mid_rst_init_done", 32'(init_done),    32'd0);
        chk("mid_rst_accel_x",   32'(accel_x),      32'd0);
        chk("mid_rst_gyro_z",    32'(gyro_z),       32'd0);
        chk("mid_rst_overrun",   32'(overrun_cnt),  32'd0);
        chk("mid_rst_valid",     32'(sample_valid), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_req",   32'(m_req), 32'd0);
        chk("idle_after_rst_valid", 32'(sample_valid), 32'd0);

        // Every attempt of the first init write NACKed -> fault
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int a = 0; a < 3; a++) begin
            wait_req("flt", t0);
            chk_write("flt", 0);
            handshake("flt");
            done_pulse(1'b1);
            if (a < 2) begin
                chk("flt_fault_early", 32'(fault), 32'd0);
                chk("flt_busy_early",  32'(busy),  32'd1);
            end
        end
        chk("flt_fault", 32'(fault), 32'd1);
        chk("flt_busy",  32'(busy),  32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_req === 1'b1) seen++;
        end
        chk("flt_no_req", 32'(seen), 32'd0);
        chk("flt_held", 32'(fault), 32'd1);

        // start from FAULT clears it and restarts the script
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_fault", 32'(fault), 32'd0);
        chk("restart_busy",  32'(busy),  32'd1);
        wait_req("restart", t0);
        chk_write("restart", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
